// File: rtl/alu_sp_pkg.sv
// rtl/alu_sp_pkg.sv - shared opcodes and state encoding for the ALU sequencer
package alu_sp_pkg;

  // Instruction opcodes accepted by the sequencer
  localparam logic [2:0] OPC_LOADI = 3'b000;
  localparam logic [2:0] OPC_MOV   = 3'b001;
  localparam logic [2:0] OPC_ADD   = 3'b010;
  localparam logic [2:0] OPC_SUB   = 3'b011;
  localparam logic [2:0] OPC_AND   = 3'b100;
  localparam logic [2:0] OPC_OR    = 3'b101;

  // ALU opcodes driven on alu_op[2:0]; 1xx is never driven
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_sp_regfile.sv
// rtl/alu_sp_regfile.sv - NREG x DW register file, two async read ports, one sync write port
module alu_sp_regfile #(
  parameter int DW   = 8,
  parameter int NREG = 4,
  localparam int RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] ra_addr_i,
  output logic [DW-1:0] ra_data_o,
  input  logic [RW-1:0] rb_addr_i,
  output logic [DW-1:0] rb_data_o,
  input  logic          we_i,
  input  logic [RW-1:0] wa_i,
  input  logic [DW-1:0] wd_i
);

  logic [DW-1:0] regs_q [NREG];

  // Storage: cleared on reset, written on the edge where we_i is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Read ports see pre-write contents, so rd aliasing ra/rb reads old values
  always_comb begin
    ra_data_o = regs_q[ra_addr_i];
    rb_data_o = regs_q[rb_addr_i];
  end

endmodule

// File: rtl/alu_sp_ctrl.sv
// rtl/alu_sp_ctrl.sv - instruction sequencer for the 8-bit ALU; ALU_SP_CTRL_SUB_EN enables SUB
module alu_sp_ctrl
  import alu_sp_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 4,
  localparam int RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_opc,
  input  logic [RW-1:0] instr_rd,
  input  logic [RW-1:0] instr_ra,
  input  logic [RW-1:0] instr_rb,
  input  logic [DW-1:0] instr_imm,
  output logic [7:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_res,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic [RW-1:0] res_rd,
  output logic          res_err
);

  state_e        state_q, state_d;
  logic [2:0]    opc_q;
  logic [RW-1:0] rd_q, ra_q, rb_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] res_data_q;
  logic [RW-1:0] res_rd_q;
  logic          res_err_q;

  logic [DW-1:0] ra_data, rb_data;
  logic          legal;
  logic          wr_en;
  logic          accept;

  assign accept = (state_q == IDLE) && instr_valid;

  // Opcode legality; SUB is only legal when its negation path is built
  always_comb begin
    legal = 1'b0;
    case (opc_q)
      OPC_LOADI, OPC_MOV, OPC_ADD, OPC_AND, OPC_OR: legal = 1'b1;
`ifdef ALU_SP_CTRL_SUB_EN
      OPC_SUB: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
  end

  alu_sp_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_addr_i (ra_q),
    .ra_data_o (ra_data),
    .rb_addr_i (rb_q),
    .rb_data_o (rb_data),
    .we_i      (wr_en),
    .wa_i      (rd_q),
    .wd_i      (alu_res)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: IDLE -> EXEC on accept, EXEC -> RESP always, RESP -> IDLE on res_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (instr_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: handshakes, write enable and ALU drive (ALU drive only in EXEC)
  always_comb begin
    instr_ready = (state_q == IDLE);
    res_valid   = (state_q == RESP);
    wr_en       = 1'b0;
    alu_op      = 8'h00;
    alu_a       = '0;
    alu_b       = '0;
    if (state_q == EXEC) begin
      wr_en = legal;
      case (opc_q)
        OPC_LOADI: begin alu_op[2:0] = ALU_FWD; alu_a = imm_q;   alu_b = imm_q;   end
        OPC_MOV:   begin alu_op[2:0] = ALU_FWD; alu_a = ra_data; alu_b = ra_data; end
        OPC_ADD:   begin alu_op[2:0] = ALU_ADD; alu_a = ra_data; alu_b = rb_data; end
`ifdef ALU_SP_CTRL_SUB_EN
        OPC_SUB:   begin alu_op[2:0] = ALU_ADD; alu_a = ra_data; alu_b = (~rb_data) + DW'(1); end
`endif
        OPC_AND:   begin alu_op[2:0] = ALU_AND; alu_a = ra_data; alu_b = rb_data; end
        OPC_OR:    begin alu_op[2:0] = ALU_OR;  alu_a = ra_data; alu_b = rb_data; end
        default:   begin alu_op[2:0] = ALU_FWD; alu_a = '0;      alu_b = '0;      end
      endcase
    end
  end

  // Datapath: capture the instruction on accept, capture the result at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q      <= '0;
      rd_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      imm_q      <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      res_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        opc_q <= instr_opc;
        rd_q  <= instr_rd;
        ra_q  <= instr_ra;
        rb_q  <= instr_rb;
        imm_q <= instr_imm;
      end
      if (state_q == EXEC) begin
        res_data_q <= legal ? alu_res : '0;
        res_rd_q   <= rd_q;
        res_err_q  <= ~legal;
      end
    end
  end

  assign res_data = res_data_q;
  assign res_rd   = res_rd_q;
  assign res_err  = res_err_q;

endmodule

// File: tb/tb_alu_sp_ctrl.sv
// tb/tb_alu_sp_ctrl.sv - directed scoreboard bench for alu_sp_ctrl with a behavioural ALU
module tb_alu_sp_ctrl;

  localparam int DW = 8;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_opc;
  logic [RW-1:0] instr_rd, instr_ra, instr_rb;
  logic [DW-1:0] instr_imm;
  logic [7:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_res;
  logic          res_valid, res_ready;
  logic [DW-1:0] res_data;
  logic [RW-1:0] res_rd;
  logic          res_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic [RW-1:0] rd;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [4];

  always #5 clk = ~clk;

  alu_sp_ctrl #(.DW(DW), .NREG(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_opc   (instr_opc),
    .instr_rd    (instr_rd),
    .instr_ra    (instr_ra),
    .instr_rb    (instr_rb),
    .instr_imm   (instr_imm),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_res     (alu_res),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_rd      (res_rd),
    .res_err     (res_err)
  );

  always_comb begin
    case (alu_op)
      8'h00:   alu_res = alu_a;
      8'h01:   alu_res = alu_a + alu_b;
      8'h02:   alu_res = alu_a & alu_b;
      8'h03:   alu_res = alu_a | alu_b;
      default: alu_res = 8'hEE;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_instr_ready"}, 32'(instr_ready), 32'd1);
    chk({tag, "_res_valid"},   32'(res_valid),   32'd0);
    chk({tag, "_res_data"},    32'(res_data),    32'd0);
    chk({tag, "_res_rd"},      32'(res_rd),      32'd0);
    chk({tag, "_res_err"},     32'(res_err),     32'd0);
    chk({tag, "_alu_op"},      32'(alu_op),      32'd0);
    chk({tag, "_alu_a"},       32'(alu_a),       32'd0);
    chk({tag, "_alu_b"},       32'(alu_b),       32'd0);
  endtask

  // One instruction end to end; hold = cycles res_ready stays low in RESP
  task automatic do_instr(input string tag, input logic [2:0] opc, input logic [1:0] rd,
                          input logic [1:0] ra, input logic [1:0] rb,
                          input logic [7:0] imm, input int hold);
    exp_t       e;
    logic [7:0] v;
    logic [7:0] op;
    logic       err;
    int         guard;
    err = 1'b0;
    v   = 8'h00;
    op  = 8'h00;
    case (opc)
      3'b000: begin v = imm;                   op = 8'h00; end
      3'b001: begin v = model[ra];             op = 8'h00; end
      3'b010: begin v = model[ra] + model[rb]; op = 8'h01; end
`ifdef ALU_SP_CTRL_SUB_EN
      3'b011: begin v = model[ra] - model[rb]; op = 8'h01; end
`else
      3'b011: err = 1'b1;
`endif
      3'b100: begin v = model[ra] & model[rb]; op = 8'h02; end
      3'b101: begin v = model[ra] | model[rb]; op = 8'h03; end
      default: err = 1'b1;
    endcase
    if (err) v = 8'h00;
    e.data = v; e.rd = rd; e.err = err;
    sb.push_back(e);
    if (!err) model[rd] = v;

    @(negedge clk);
    instr_opc = opc; instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_imm = imm;
    instr_valid = 1'b1;
    res_ready   = (hold == 0);
    guard = 0;
    while (!instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_accept_wait"}, 32'(instr_ready), 32'd1);

    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_opc = 3'b110; instr_imm = 8'hA5;
    chk({tag, "_exec_instr_ready"}, 32'(instr_ready), 32'd0);
    chk({tag, "_exec_res_valid"},   32'(res_valid),   32'd0);
    chk({tag, "_exec_alu_op"},      32'(alu_op),      32'(op));
    if (!err && opc <= 3'b001) begin
      chk({tag, "_exec_fwd_a"}, 32'(alu_a), 32'(v));
      chk({tag, "_exec_fwd_b"}, 32'(alu_b), 32'(v));
    end

    @(posedge clk); #1;
    chk({tag, "_resp_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_resp_alu_op"}, 32'(alu_op), 32'd0);
    if (res_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_res_data"}, 32'(res_data), 32'(e.data));
      chk({tag, "_res_rd"},   32'(res_rd),   32'(e.rd));
      chk({tag, "_res_err"},  32'(res_err),  32'(e.err));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        chk({tag, "_hold_valid"},       32'(res_valid),   32'd1);
        chk({tag, "_hold_instr_ready"}, 32'(instr_ready), 32'd0);
        chk({tag, "_hold_data"},        32'(res_data),    32'(e.data));
        chk({tag, "_hold_rd"},          32'(res_rd),      32'(e.rd));
        chk({tag, "_hold_err"},         32'(res_err),     32'(e.err));
      end
    end else begin
      if (sb.size() > 0) void'(sb.pop_front());
      chk({tag, "_result_missing"}, 32'(res_valid), 32'd1);
    end

    res_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_done_valid"}, 32'(res_valid),   32'd0);
    chk({tag, "_done_ready"}, 32'(instr_ready), 32'd1);
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0; instr_opc = '0; instr_rd = '0; instr_ra = '0; instr_rb = '0;
    instr_imm = '0; res_ready = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    do_instr("loadi_r1",  3'b000, 2'd1, 2'd0, 2'd0, 8'h5A, 0);
    do_instr("mov_r2_r1", 3'b001, 2'd2, 2'd1, 2'd0, 8'h00, 0);

    do_instr("loadi_r0_f0", 3'b000, 2'd0, 2'd0, 2'd0, 8'hF0, 0);
    do_instr("loadi_r1_20", 3'b000, 2'd1, 2'd0, 2'd0, 8'h20, 0);
    do_instr("add_wrap",    3'b010, 2'd2, 2'd0, 2'd1, 8'h00, 0);

    do_instr("loadi_r0_05", 3'b000, 2'd0, 2'd0, 2'd0, 8'h05, 0);
    do_instr("loadi_r1_07", 3'b000, 2'd1, 2'd0, 2'd0, 8'h07, 0);
    do_instr("loadi_r3_33", 3'b000, 2'd3, 2'd0, 2'd0, 8'h33, 0);
    do_instr("sub_r3",      3'b011, 2'd3, 2'd0, 2'd1, 8'h00, 0);
    do_instr("read_r3",     3'b001, 2'd2, 2'd3, 2'd0, 8'h00, 0);

    do_instr("loadi_r0_cc", 3'b000, 2'd0, 2'd0, 2'd0, 8'hCC, 0);
    do_instr("loadi_r1_aa", 3'b000, 2'd1, 2'd0, 2'd0, 8'hAA, 0);
    do_instr("and_alias",   3'b100, 2'd0, 2'd0, 2'd1, 8'h00, 0);
    do_instr("or_alias",    3'b101, 2'd1, 2'd0, 2'd1, 8'h00, 0);

    do_instr("loadi_r2_3c", 3'b000, 2'd2, 2'd0, 2'd0, 8'h3C, 0);
    do_instr("illegal_111", 3'b111, 2'd2, 2'd0, 2'd1, 8'hFF, 0);
    do_instr("illegal_110", 3'b110, 2'd2, 2'd1, 2'd0, 8'h11, 0);
    do_instr("read_r2",     3'b001, 2'd3, 2'd2, 2'd0, 8'h00, 0);

    do_instr("add_hold5",   3'b010, 2'd3, 2'd0, 2'd1, 8'h00, 5);

    @(negedge clk);
    instr_opc = 3'b000; instr_rd = 2'd1; instr_imm = 8'h77; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("rst_exec_alu_a", 32'(alu_a), 32'h77);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 8'h00;
    #1;
    chk_reset_outputs("rst_in_exec");
    @(posedge clk); #1;
    chk_reset_outputs("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    do_instr("after_rst_r1", 3'b001, 2'd2, 2'd1, 2'd0, 8'h00, 0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sp_ctrl.md
# alu_sp_ctrl

Instruction sequencer for the 8-bit special-purpose ALU. Accepts one instruction at a time over a valid/ready handshake and reads operands from a private register file. Drives the ALU opcode and operands, writes the ALU result back, and returns the result over a second valid/ready handshake. It is the only master of the ALU's op, in_a and in_b inputs.

## Interface
- DW, 8, datapath width; must match the ALU width.
- NREG, 4, number of registers; power of two, at least 2.
- RW, $clog2(NREG), register index width; derived, not overridden.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  controller can accept an instruction.
- instr_opc  in  3  instruction opcode.
- instr_rd  in  RW  destination register.
- instr_ra  in  RW  source register A.
- instr_rb  in  RW  source register B.
- instr_imm  in  DW  immediate for LOADI.
- alu_op  out  8  ALU opcode; bits [7:3] always 0.
- alu_a  out  DW  ALU operand A.
- alu_b  out  DW  ALU operand B.
- alu_res  in  DW  ALU result, combinational from alu_op/alu_a/alu_b.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts result.
- res_data  out  DW  value written to rd; 0 on error.
- res_rd  out  RW  destination index of this result.
- res_err  out  1  instruction was illegal; no write-back occurred.

## Operation
- Instruction opcodes:
  - 000 LOADI: rd = imm.
  - 001 MOV: rd = ra.
  - 010 ADD: rd = ra + rb.
  - 011 SUB: rd = ra - rb.
  - 100 AND: rd = ra & rb.
  - 101 OR: rd = ra | rb.
  - 110 and 111: illegal.
- ALU opcodes driven:
  - FWD = 000.
  - ADD = 001.
  - AND = 010.
  - OR = 011.
  - Opcodes 1xx are never driven.
- Forwarding (LOADI, MOV): the forwarded value is driven on both alu_a and alu_b.
- SUB: drives ADD with alu_b = ~rb + 1.
- Arithmetic is modulo 2^DW. No carry or overflow is reported.
- State machine, registered state:
  - IDLE: instr_ready=1. On instr_valid, capture all instr_* fields and go to EXEC.
  - EXEC: operands are driven from the captured fields and current register contents. At the clock edge, alu_res is captured into res_data. If the opcode is legal, alu_res is written to reg[rd]. Go to RESP.
  - RESP: res_valid=1. Go to IDLE when res_ready=1; otherwise hold.
- Outputs outside EXEC:
  - alu_op, alu_a and alu_b are 0.
  - The ALU is idle and its output is ignored.
- Illegal opcode: EXEC performs no register write, res_data=0, res_err=1.
- Register file reset value: all entries 0.
- Aliasing: rd may equal ra or rb. Operands are read before the write-back edge, so they hold old values.

## Timing
- Reset values: state IDLE, instr_ready=1, res_valid=0, res_data=0, res_rd=0, res_err=0, alu_op=0, alu_a=0, alu_b=0.
- Latency: an instruction accepted at edge N has its write-back at edge N+1. res_valid is high from after edge N+1.
- Earliest next instruction: if res_ready is high in that first RESP cycle, the next accept is at edge N+3. Peak throughput is 1 instruction per 3 cycles.
- instr_ready is low in EXEC and RESP. The instr_* inputs are sampled only on the accept edge.
- res_* outputs are stable while res_valid=1 and res_ready=0.
- res_ready asserted outside RESP is ignored.
- Reset asserted in EXEC: no write-back, and the instruction is lost.
- Reset asserted in RESP: the pending result is dropped.
- Reset deassertion takes effect at the first rising clk edge after rst_n rises.

## Configuration
- ALU_SP_CTRL_SUB_EN defined: opcode 011 executes SUB as described in Operation.
- ALU_SP_CTRL_SUB_EN undefined: opcode 011 is illegal and follows the illegal-opcode rules. The negation logic is not built.

## Structure
- Shared package alu_sp_pkg contains:
  - Instruction opcode localparams.
  - ALU opcode localparams: FWD, ADD, AND, OR.
  - The controller state enum: IDLE, EXEC, RESP.
- Sub-module alu_sp_regfile:
  - NREG x DW registers with asynchronous reset to 0.
  - Two combinational read ports and one synchronous write port.
- The ALU itself is instantiated beside the controller, not inside it.

## Test plan
- Reset, then LOADI r1=0x5A and read back with MOV r2=r1: res_data=0x5A, res_rd=2, res_err=0. First result arrives 1 cycle after accept.
- LOADI r0=0xF0, LOADI r1=0x20, ADD r2=r0,r1: res_data=0x10 (wrap-around, no flag).
- With r0=0x05, r1=0x07 and the macro defined, SUB r3=r0,r1 gives res_data=0xFE. With the macro undefined, the same instruction gives res_err=1, res_data=0, and r3 is unchanged.
- With r0=0xCC, r1=0xAA: AND r0=r0,r1 gives 0x88, then OR r1=r0,r1 gives 0xAA. This checks the rd=ra alias and write-back ordering.
- Opcode 111 with rd=2: res_err=1, r2 is unchanged, and alu_op never leaves 000.
- Hold res_ready=0 for 5 cycles: res_* are stable and instr_ready stays 0. Assert rst_n low in EXEC: no write, and all outputs return to their reset values.
